// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types for the ALU sequencing controller.
//   STATE_W        : width of the state encoding / state_code LED bus
//   state_t        : controller states, encodings are visible on state_code
//   is_entry_wait  : true in the states where the controller waits for an
//                    operand B or opcode entry (the watchdog counts there)
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [2:0] {
    WAIT_A      = 3'd0,
    WAIT_B      = 3'd1,
    WAIT_OP     = 3'd2,
    COMPUTE     = 3'd3,
    SHOW_RESULT = 3'd4
  } state_t;

  function automatic logic is_entry_wait(input state_t s);
    return (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
// One-flop rising-edge detector for an already synchronized level.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (flop clears to 0)
//   d     : synchronized input level
//   pulse : d & ~d_delayed, one cycle per rising edge of d
// -----------------------------------------------------------------------------
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic q_r;

  // Delayed copy of the input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else begin
      q_r <= d;
    end
  end

  assign pulse = d & ~q_r;

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Walks the user through entering operand A, operand B and the opcode with a
// single enter button, then commits the ALU result/flags.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   enter        : debounced, synchronized button level (rising edge = command)
//   clear        : synchronous abort, returns to WAIT_A, beats enter
//   load_A       : strobe to operand A register (same cycle as the enter edge)
//   load_B       : strobe to operand B register
//   load_Op      : strobe to opcode register
//   updateRes    : strobe to result/flags registers, the cycle after load_Op
//   state_code   : current state encoding (alu_ctrl_pkg::state_t)
//   result_valid : high while in SHOW_RESULT
//   timeout      : one-cycle pulse when the watchdog aborts an entry
// Build option:
//   ALU_SEQ_CTRL_TIMEOUT_EN : when defined, an entry left idle in WAIT_B or
//   WAIT_OP for TIMEOUT_CYCLES cycles is aborted back to WAIT_A. Otherwise
//   timeout is tied low and entry waits indefinitely.
// N is carried only to match the datapath parameter list.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N              = 16,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               clear,
  output logic               load_A,
  output logic               load_B,
  output logic               load_Op,
  output logic               updateRes,
  output logic [STATE_W-1:0] state_code,
  output logic               result_valid,
  output logic               timeout
);

  // Elaboration-time guard on nonsensical parameter values.
  if (N < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("alu_seq_ctrl: N must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  state_t state_r;
  state_t state_nxt_s;
  logic   raw_pulse_s;
  logic   enter_pulse_s;
  logic   armed_r;
  logic   tmo_hit_s;
  logic   load_a_s;
  logic   load_b_s;
  logic   load_op_s;
  logic   update_s;
  logic   timeout_s;

  rise_edge_det u_enter_edge (
    .clk   (clk),
    .rst_n (reset),
    .d     (enter),
    .pulse (raw_pulse_s)
  );

  // Blocks the edge detector until its flop has sampled enter once after
  // reset; otherwise a button already held at release would look like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  assign enter_pulse_s = raw_pulse_s & armed_r;

`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt_r;

  // Idle counter for the operand-B / opcode entry states; restarts on any
  // activity so only a genuinely idle entry can expire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (clear || enter_pulse_s || (state_nxt_s != state_r) ||
                 !is_entry_wait(state_r)) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end

  assign tmo_hit_s = is_entry_wait(state_r) &&
                     (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and strobe decode. Load strobes are Mealy so the datapath
  // captures data_in on the same edge the state advances; an enter edge in
  // the same cycle as a watchdog expiry takes precedence over the expiry.
  always_comb begin
    state_nxt_s = state_r;
    load_a_s    = 1'b0;
    load_b_s    = 1'b0;
    load_op_s   = 1'b0;
    update_s    = 1'b0;
    timeout_s   = 1'b0;
    if (clear) begin
      state_nxt_s = WAIT_A;
    end else begin
      case (state_r)
        WAIT_A: begin
          if (enter_pulse_s) begin
            load_a_s    = 1'b1;
            state_nxt_s = WAIT_B;
          end else begin
            state_nxt_s = WAIT_A;
          end
        end
        WAIT_B: begin
          if (enter_pulse_s) begin
            load_b_s    = 1'b1;
            state_nxt_s = WAIT_OP;
          end else if (tmo_hit_s) begin
            timeout_s   = 1'b1;
            state_nxt_s = WAIT_A;
          end else begin
            state_nxt_s = WAIT_B;
          end
        end
        WAIT_OP: begin
          if (enter_pulse_s) begin
            load_op_s   = 1'b1;
            state_nxt_s = COMPUTE;
          end else if (tmo_hit_s) begin
            timeout_s   = 1'b1;
            state_nxt_s = WAIT_A;
          end else begin
            state_nxt_s = WAIT_OP;
          end
        end
        COMPUTE: begin
          update_s    = 1'b1;
          state_nxt_s = SHOW_RESULT;
        end
        SHOW_RESULT: begin
          if (enter_pulse_s) begin
            state_nxt_s = WAIT_A;
          end else begin
            state_nxt_s = SHOW_RESULT;
          end
        end
        default: begin
          state_nxt_s = WAIT_A;
        end
      endcase
    end
  end

  assign load_A       = load_a_s;
  assign load_B       = load_b_s;
  assign load_Op      = load_op_s;
  assign updateRes    = update_s;
  assign timeout      = timeout_s;
  assign state_code   = state_r;
  assign result_valid = (state_r == SHOW_RESULT);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed bench for alu_seq_ctrl. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge. Operand values (A=0x0005, B=0x0003,
// op=0x0000) live in the datapath; here only the strobes are observed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       load_A, load_B, load_Op, updateRes;
  logic [2:0] state_code;
  logic       result_valid, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.N(16), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enter        (enter),
    .clear        (clear),
    .load_A       (load_A),
    .load_B       (load_B),
    .load_Op      (load_Op),
    .updateRes    (updateRes),
    .state_code   (state_code),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {load_A, load_B, load_Op, updateRes};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the falling edge and compare state, strobes and timeout.
  task automatic chk_out(input string tag, input logic [2:0] st, input logic [3:0] stb);
    @(negedge clk);
    check({tag, ".state"}, 32'(state_code), 32'(st));
    check({tag, ".strb"}, 32'(strobes()), 32'(stb));
    check({tag, ".tmo"}, 32'(timeout), 32'd0);
  endtask

  // Raise enter for one cycle and check the cycle of the edge.
  task automatic pulse(input string tag, input logic [2:0] st, input logic [3:0] stb);
    enter = 1'b1;
    chk_out(tag, st, stb);
    cyc();
    enter = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n_a;
    int n_other;

    // Reset state
    #2;
    check("rst.state", 32'(state_code), 32'd0);
    check("rst.strb", 32'(strobes()), 32'd0);
    check("rst.rv", 32'(result_valid), 32'd0);
    check("rst.tmo", 32'(timeout), 32'd0);
    repeat (2) cyc();
    reset = 1'b1;
    chk_out("rst_rel", 3'd0, 4'b0000);
    cyc();

    // Full sequence: A, B, Op, then updateRes one cycle later
    pulse("seqA", 3'd0, 4'b1000);
    chk_out("seqA_after", 3'd1, 4'b0000);
    cyc();
    pulse("seqB", 3'd1, 4'b0100);
    chk_out("seqB_after", 3'd2, 4'b0000);
    cyc();
    pulse("seqOp", 3'd2, 4'b0010);
    chk_out("seqCompute", 3'd3, 4'b0001);
    check("seqCompute.rv", 32'(result_valid), 32'd0);
    cyc();
    chk_out("seqShow", 3'd4, 4'b0000);
    check("seqShow.rv", 32'(result_valid), 32'd1);
    cyc();

    // Enter in SHOW_RESULT: back to WAIT_A silently, then a new A loads
    pulse("showEnter", 3'd4, 4'b0000);
    chk_out("showEnter_after", 3'd0, 4'b0000);
    check("showEnter_after.rv", 32'(result_valid), 32'd0);
    cyc();
    pulse("reloadA", 3'd0, 4'b1000);
    chk_out("reloadA_after", 3'd1, 4'b0000);   // cycle 1 in WAIT_B
    cyc();

`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
    // Idle in WAIT_B: timeout on the 8th cycle
    for (int i = 2; i <= 7; i++) begin
      chk_out("idleB", 3'd1, 4'b0000);
      cyc();
    end
    @(negedge clk);
    check("tmo8.pulse", 32'(timeout), 32'd1);
    check("tmo8.strb", 32'(strobes()), 32'd0);
    cyc();
    chk_out("tmo_after", 3'd0, 4'b0000);
    cyc();
    // Re-enter WAIT_B, press at cycle 7: load_B wins, no timeout
    pulse("toA", 3'd0, 4'b1000);               // now in WAIT_B cycle 1
    for (int i = 1; i <= 6; i++) begin
      chk_out("idleB2", 3'd1, 4'b0000);
      cyc();
    end
    pulse("tmoEnter7", 3'd1, 4'b0100);
    chk_out("tmoEnter7_after", 3'd2, 4'b0000);
    cyc();
    chk_out("tmoEnter7_after2", 3'd2, 4'b0000);
    cyc();
`else
    // No watchdog: WAIT_B holds indefinitely
    for (int i = 0; i < 12; i++) begin
      chk_out("idleB", 3'd1, 4'b0000);
      cyc();
    end
    pulse("idleB_enter", 3'd1, 4'b0100);
    chk_out("idleB_enter_after", 3'd2, 4'b0000);
    cyc();
`endif

    // clear and enter edge together in WAIT_OP: clear wins
    enter = 1'b1;
    clear = 1'b1;
    chk_out("clrOp", 3'd2, 4'b0000);
    cyc();
    enter = 1'b0;
    clear = 1'b0;
    chk_out("clrOp_after", 3'd0, 4'b0000);
    cyc();

    // enter held for 50 cycles in WAIT_A: exactly one load_A
    n_a = 0;
    n_other = 0;
    enter = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (load_A) n_a++;
      if (load_B || load_Op || updateRes || timeout) n_other++;
      cyc();
    end
    check("held.loadA_count", 32'(n_a), 32'd1);
    check("held.other_count", 32'(n_other), 32'd0);
    check("held.state", 32'(state_code), 32'd1);
    enter = 1'b0;
    cyc();

    // Reach COMPUTE, then assert reset mid-cycle
    pulse("rB", 3'd1, 4'b0100);
    chk_out("rB_after", 3'd2, 4'b0000);
    cyc();
    enter = 1'b1;
    chk_out("rOp", 3'd2, 4'b0010);
    cyc();
    check("rCompute.upd", 32'(updateRes), 32'd1);
    reset = 1'b0;
    #1;
    check("rAsync.upd", 32'(updateRes), 32'd0);
    check("rAsync.state", 32'(state_code), 32'd0);
    check("rAsync.strb", 32'(strobes()), 32'd0);
    cyc();
    cyc();
    // Release with enter already high: no pulse
    reset = 1'b1;
    chk_out("relHeld", 3'd0, 4'b0000);
    check("relHeld.rv", 32'(result_valid), 32'd0);
    cyc();
    chk_out("relHeld2", 3'd0, 4'b0000);
    cyc();
    enter = 1'b0;
    cyc();
    pulse("postA", 3'd0, 4'b1000);
    chk_out("postA_after", 3'd1, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
